// File: rtl/register_read_stage_pkg.sv
// Shared types and constants for the register-read stage.
// Widths match the register-file package: 16 registers, r0 hard-wired zero.
package register_read_stage_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned SEL_WIDTH  = 4;
   localparam int unsigned CTRL_WIDTH = 32;
   localparam int unsigned CNT_WIDTH  = 32;

   // One decoded instruction as offered by decode.
   typedef struct packed {
      logic [SEL_WIDTH-1:0]  sel_ra;
      logic [SEL_WIDTH-1:0]  sel_rb;
      logic [SEL_WIDTH-1:0]  sel_rc;
      logic                  use_ra;
      logic                  use_rb;
      logic                  use_rc;
      logic [CTRL_WIDTH-1:0] ctrl;
   } rr_in_t;

   // A result bus that can be forwarded into operand resolution (execute or writeback).
   typedef struct packed {
      logic                  en;
      logic [SEL_WIDTH-1:0]  sel;
      logic [DATA_WIDTH-1:0] data;
   } rr_fwd_t;

   // Resolved instruction as handed to execute.
   typedef struct packed {
      logic [DATA_WIDTH-1:0] data_ra;
      logic [DATA_WIDTH-1:0] data_rb;
      logic [DATA_WIDTH-1:0] data_rc;
      logic [SEL_WIDTH-1:0]  sel_ra;
      logic [SEL_WIDTH-1:0]  sel_rb;
      logic [SEL_WIDTH-1:0]  sel_rc;
      logic [CTRL_WIDTH-1:0] ctrl;
   } rr_out_t;

   // True when a forwarding bus carries a live value for a non-zero source register.
   function automatic logic fwd_hit(input logic [SEL_WIDTH-1:0] sel, input rr_fwd_t fwd);
      return fwd.en && (fwd.sel == sel) && (sel != '0);
   endfunction

   // True when a source that is actually read names the given destination.
   function automatic logic src_match(input logic [SEL_WIDTH-1:0] sel,
                                      input logic                 used,
                                      input logic [SEL_WIDTH-1:0] dest);
      return used && (sel == dest);
   endfunction

endpackage

// File: rtl/register_read_stage_operand_forward_mux.sv
// Per-operand priority select: zero register, execute forward, writeback forward, register file.
module operand_forward_mux
   import register_read_stage_pkg::*;
(
   input  logic [SEL_WIDTH-1:0]  sel,
   input  rr_fwd_t               ex_fwd,
   input  rr_fwd_t               wb_fwd,
   input  logic [DATA_WIDTH-1:0] rf_data,
   output logic [DATA_WIDTH-1:0] data_c
);

   // Youngest producer wins; a writeback in the data-arrival cycle is not seen by the RF bypass.
   always_comb begin
      data_c = rf_data;
      if (sel == '0) begin
         data_c = '0;
      end else if (fwd_hit(sel, ex_fwd)) begin
         data_c = ex_fwd.data;
      end else if (fwd_hit(sel, wb_fwd)) begin
         data_c = wb_fwd.data;
      end
   end

endmodule

// File: rtl/register_read_stage.sv
// Register-read pipeline stage between decode and execute.
// Holds one instruction, drives the register-file read selects, resolves operands
// with execute/writeback forwarding and stalls on load-use hazards.
// Optional performance counters: define REGISTER_READ_STAGE_PERF_CNT_EN.
module register_read_stage
   import register_read_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SEL_WIDTH-1:0]  in_sel_ra,
   input  logic [SEL_WIDTH-1:0]  in_sel_rb,
   input  logic [SEL_WIDTH-1:0]  in_sel_rc,
   input  logic                  in_use_ra,
   input  logic                  in_use_rb,
   input  logic                  in_use_rc,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,

   output logic [SEL_WIDTH-1:0]  rf_read_sel_ra,
   output logic [SEL_WIDTH-1:0]  rf_read_sel_rb,
   output logic [SEL_WIDTH-1:0]  rf_read_sel_rc,
   input  logic [DATA_WIDTH-1:0] rf_read_data_ra,
   input  logic [DATA_WIDTH-1:0] rf_read_data_rb,
   input  logic [DATA_WIDTH-1:0] rf_read_data_rc,

   input  logic                  ex_fwd_en,
   input  logic [SEL_WIDTH-1:0]  ex_dest,
   input  logic [DATA_WIDTH-1:0] ex_data,
   input  logic                  ex_load_pending,

   input  logic                  wb_write_en,
   input  logic [SEL_WIDTH-1:0]  wb_write_sel,
   input  logic [DATA_WIDTH-1:0] wb_write_data,

   input  logic                  flush,

   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data_ra,
   output logic [DATA_WIDTH-1:0] out_data_rb,
   output logic [DATA_WIDTH-1:0] out_data_rc,
   output logic [SEL_WIDTH-1:0]  out_sel_ra,
   output logic [SEL_WIDTH-1:0]  out_sel_rb,
   output logic [SEL_WIDTH-1:0]  out_sel_rc,
   output logic [CTRL_WIDTH-1:0] out_ctrl
`ifdef REGISTER_READ_STAGE_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  out_cnt_stall,
   output logic [CNT_WIDTH-1:0]  out_cnt_fwd
`endif
);

   rr_in_t                in_bus;
   rr_in_t                h_in_q;
   rr_in_t                h_in_d;
   logic                  h_valid_q;
   logic                  h_valid_d;
   rr_fwd_t               ex_fwd;
   rr_fwd_t               wb_fwd;
   rr_out_t               out_bus;
   logic                  hazard_c;
   logic                  accept_c;
   logic                  deliver_c;
   logic [DATA_WIDTH-1:0] data_ra_c;
   logic [DATA_WIDTH-1:0] data_rb_c;
   logic [DATA_WIDTH-1:0] data_rc_c;

   // Gather the decode offer and the two forwarding buses into bundles.
   always_comb begin
      in_bus.sel_ra = in_sel_ra;
      in_bus.sel_rb = in_sel_rb;
      in_bus.sel_rc = in_sel_rc;
      in_bus.use_ra = in_use_ra;
      in_bus.use_rb = in_use_rb;
      in_bus.use_rc = in_use_rc;
      in_bus.ctrl   = in_ctrl;

      ex_fwd.en     = ex_fwd_en;
      ex_fwd.sel    = ex_dest;
      ex_fwd.data   = ex_data;

      wb_fwd.en     = wb_write_en;
      wb_fwd.sel    = wb_write_sel;
      wb_fwd.data   = wb_write_data;
   end

   // Load-use hazard: a read source of the held instruction waits on an outstanding load.
   always_comb begin
      hazard_c = 1'b0;
      if (h_valid_q && ex_load_pending && (ex_dest != '0)) begin
         hazard_c = src_match(h_in_q.sel_ra, h_in_q.use_ra, ex_dest)
                 || src_match(h_in_q.sel_rb, h_in_q.use_rb, ex_dest)
                 || src_match(h_in_q.sel_rc, h_in_q.use_rc, ex_dest);
      end
   end

   // Handshake on both sides; nothing moves while reset is asserted or in a flush cycle.
   always_comb begin
      out_valid = 1'b0;
      in_ready  = 1'b0;
      if (!rst) begin
         out_valid = h_valid_q && !hazard_c && !flush;
         in_ready  = !flush && (!h_valid_q || (out_ready && !hazard_c));
      end
   end

   assign accept_c  = in_valid && in_ready;
   assign deliver_c = out_valid && out_ready;

   // Next held state: flush beats accept, accept beats drain.
   always_comb begin
      h_valid_d = h_valid_q;
      h_in_d    = h_in_q;
      if (flush) begin
         h_valid_d = 1'b0;
      end else if (accept_c) begin
         h_valid_d = 1'b1;
         h_in_d    = in_bus;
      end else if (deliver_c) begin
         h_valid_d = 1'b0;
      end
   end

   // Read selects follow the incoming instruction on accept, otherwise re-read the held one
   // so that register-file data always corresponds to the held selects.
   always_comb begin
      rf_read_sel_ra = accept_c ? in_sel_ra : h_in_q.sel_ra;
      rf_read_sel_rb = accept_c ? in_sel_rb : h_in_q.sel_rb;
      rf_read_sel_rc = accept_c ? in_sel_rc : h_in_q.sel_rc;
   end

   // Held-instruction register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_valid_q <= 1'b0;
         h_in_q    <= '0;
      end else begin
         h_valid_q <= h_valid_d;
         h_in_q    <= h_in_d;
      end
   end

   operand_forward_mux u_mux_ra (
      .sel     (h_in_q.sel_ra),
      .ex_fwd  (ex_fwd),
      .wb_fwd  (wb_fwd),
      .rf_data (rf_read_data_ra),
      .data_c  (data_ra_c)
   );

   operand_forward_mux u_mux_rb (
      .sel     (h_in_q.sel_rb),
      .ex_fwd  (ex_fwd),
      .wb_fwd  (wb_fwd),
      .rf_data (rf_read_data_rb),
      .data_c  (data_rb_c)
   );

   operand_forward_mux u_mux_rc (
      .sel     (h_in_q.sel_rc),
      .ex_fwd  (ex_fwd),
      .wb_fwd  (wb_fwd),
      .rf_data (rf_read_data_rc),
      .data_c  (data_rc_c)
   );

   // Assemble the resolved instruction for execute.
   always_comb begin
      out_bus.data_ra = data_ra_c;
      out_bus.data_rb = data_rb_c;
      out_bus.data_rc = data_rc_c;
      out_bus.sel_ra  = h_in_q.sel_ra;
      out_bus.sel_rb  = h_in_q.sel_rb;
      out_bus.sel_rc  = h_in_q.sel_rc;
      out_bus.ctrl    = h_in_q.ctrl;
   end

   assign out_data_ra = out_bus.data_ra;
   assign out_data_rb = out_bus.data_rb;
   assign out_data_rc = out_bus.data_rc;
   assign out_sel_ra  = out_bus.sel_ra;
   assign out_sel_rb  = out_bus.sel_rb;
   assign out_sel_rc  = out_bus.sel_rc;
   assign out_ctrl    = out_bus.ctrl;

`ifdef REGISTER_READ_STAGE_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_stall_q;
   logic [CNT_WIDTH-1:0] cnt_stall_d;
   logic [CNT_WIDTH-1:0] cnt_fwd_q;
   logic [CNT_WIDTH-1:0] cnt_fwd_d;
   logic                 any_fwd_c;

   // Saturating counters: hazard cycles, and delivered instructions using any forwarded operand.
   always_comb begin
      any_fwd_c = fwd_hit(h_in_q.sel_ra, ex_fwd) || fwd_hit(h_in_q.sel_ra, wb_fwd)
               || fwd_hit(h_in_q.sel_rb, ex_fwd) || fwd_hit(h_in_q.sel_rb, wb_fwd)
               || fwd_hit(h_in_q.sel_rc, ex_fwd) || fwd_hit(h_in_q.sel_rc, wb_fwd);
      cnt_stall_d = cnt_stall_q;
      cnt_fwd_d   = cnt_fwd_q;
      if (hazard_c && (cnt_stall_q != '1)) begin
         cnt_stall_d = cnt_stall_q + CNT_WIDTH'(1);
      end
      if (deliver_c && any_fwd_c && (cnt_fwd_q != '1)) begin
         cnt_fwd_d = cnt_fwd_q + CNT_WIDTH'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_stall_q <= '0;
         cnt_fwd_q   <= '0;
      end else begin
         cnt_stall_q <= cnt_stall_d;
         cnt_fwd_q   <= cnt_fwd_d;
      end
   end

   assign out_cnt_stall = cnt_stall_q;
   assign out_cnt_fwd   = cnt_fwd_q;
`endif

endmodule
